// File: rtl/spi_send_stream.sv
// Streams ready/valid words over LINES parallel SPI-style data lines.
// Generates DCLK and CS itself; back-to-back words share one CS-low burst.
module spi_send_stream #(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned LINES           = 4,
  parameter int unsigned DATA_CLK_PERIOD = 100,
  parameter bit          MSB_FIRST       = 1'b1,
  parameter int unsigned CS_GAP          = 50,
  parameter int unsigned STALL_TIMEOUT   = 1000
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_last_in,
  input  logic                  data_valid_in,
  output logic                  data_ready_out,
  output logic [LINES-1:0]      chip_data_out,
  output logic                  chip_clk_out,
  output logic                  chip_sel_out,
  output logic                  busy_out,
  output logic                  word_done_out,
  output logic                  underrun_out
);
  localparam int unsigned BEATS = DATA_WIDTH / LINES;
  localparam int unsigned HALF  = DATA_CLK_PERIOD / 2;
  localparam int unsigned HW    = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned SW    = (STALL_TIMEOUT > 1) ? $clog2(STALL_TIMEOUT) : 1;
  localparam int unsigned GW    = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, STALL, GAP} state_t;

  state_t                state_q, state_d;
  logic                  hold_full_q, hold_full_d;
  logic                  hold_last_q, hold_last_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic                  last_q, last_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic [HW-1:0]         hcnt_q, hcnt_d;
  logic [SW-1:0]         scnt_q, scnt_d;
  logic [GW-1:0]         gcnt_q, gcnt_d;
  logic                  ready_d, dclk_d, cs_d, busy_d, done_d, undr_d;
  logic [LINES-1:0]      data_d;
  logic                  accept, load;

  // Beat presented first from a word, and the word with that beat consumed.
  function automatic logic [LINES-1:0] first_beat(input logic [DATA_WIDTH-1:0] w);
    if (MSB_FIRST) return w[DATA_WIDTH-1 -: LINES];
    else           return w[LINES-1:0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] w);
    if (MSB_FIRST) return w << LINES;
    else           return w >> LINES;
  endfunction

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    sh_d    = sh_q;
    last_d  = last_q;
    beat_d  = beat_q;
    hcnt_d  = hcnt_q;
    scnt_d  = scnt_q;
    gcnt_d  = gcnt_q;
    dclk_d  = chip_clk_out;
    cs_d    = chip_sel_out;
    data_d  = chip_data_out;
    done_d  = 1'b0;
    undr_d  = 1'b0;
    accept  = data_valid_in & data_ready_out;

    case (state_q)
      IDLE: begin
        cs_d   = 1'b1;
        dclk_d = 1'b0;
        if (hold_full_q) begin
          load    = 1'b1;
          cs_d    = 1'b0;
          hcnt_d  = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (hcnt_q == HW'(HALF - 1)) begin
          hcnt_d = '0;
          dclk_d = ~chip_clk_out;
          // Data only moves on the DCLK falling edge; the receiver samples on the rise.
          if (chip_clk_out) begin
            if (beat_q != BW'(BEATS - 1)) begin
              beat_d = beat_q + BW'(1);
              data_d = first_beat(sh_q);
              sh_d   = advance(sh_q);
            end else begin
              done_d = 1'b1;
              if (hold_full_q) begin
                load = 1'b1;
              end else if (last_q) begin
                cs_d    = 1'b1;
                data_d  = '0;
                gcnt_d  = '0;
                state_d = GAP;
              end else begin
                scnt_d  = '0;
                state_d = STALL;
              end
            end
          end
        end else begin
          hcnt_d = hcnt_q + HW'(1);
        end
      end
      STALL: begin
        if (hold_full_q) begin
          load    = 1'b1;
          hcnt_d  = '0;
          state_d = SHIFT;
        end else if (scnt_q == SW'(STALL_TIMEOUT - 1)) begin
          cs_d    = 1'b1;
          data_d  = '0;
          undr_d  = 1'b1;
          gcnt_d  = '0;
          state_d = GAP;
        end else begin
          scnt_d = scnt_q + SW'(1);
        end
      end
      GAP: begin
        if (gcnt_q == GW'(CS_GAP - 1)) state_d = IDLE;
        else                           gcnt_d  = gcnt_q + GW'(1);
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      sh_d   = advance(hold_data_q);
      data_d = first_beat(hold_data_q);
      last_d = hold_last_q;
      beat_d = '0;
    end

    // Accept and load are exclusive: accept needs the holding register empty, load needs it full.
    hold_full_d = accept ? 1'b1 : (load ? 1'b0 : hold_full_q);
    hold_data_d = accept ? data_in : hold_data_q;
    hold_last_d = accept ? data_last_in : hold_last_q;
    ready_d     = ~hold_full_d;
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      hold_full_q    <= 1'b0;
      hold_last_q    <= 1'b0;
      hold_data_q    <= '0;
      sh_q           <= '0;
      last_q         <= 1'b0;
      beat_q         <= '0;
      hcnt_q         <= '0;
      scnt_q         <= '0;
      gcnt_q         <= '0;
      data_ready_out <= 1'b0;
      chip_data_out  <= '0;
      chip_clk_out   <= 1'b0;
      chip_sel_out   <= 1'b1;
      busy_out       <= 1'b0;
      word_done_out  <= 1'b0;
      underrun_out   <= 1'b0;
    end else begin
      hold_full_q    <= hold_full_d;
      hold_last_q    <= hold_last_d;
      hold_data_q    <= hold_data_d;
      sh_q           <= sh_d;
      last_q         <= last_d;
      beat_q         <= beat_d;
      hcnt_q         <= hcnt_d;
      scnt_q         <= scnt_d;
      gcnt_q         <= gcnt_d;
      data_ready_out <= ready_d;
      chip_data_out  <= data_d;
      chip_clk_out   <= dclk_d;
      chip_sel_out   <= cs_d;
      busy_out       <= busy_d;
      word_done_out  <= done_d;
      underrun_out   <= undr_d;
    end
  end
endmodule
